gpio_walk_checker: RTL

- Synthesizable, parametrised monitor for walking-bit sequences on a GPIO-width bus.
- Given a WIDTH-bit bus, it checks for ITERATIONS rounds of an idle pattern followed by single-bit steps 0..WIDTH-1, then a final idle. It reports pass, timeout or mismatch.
- Sits beside a team design inside the user project, so on-chip self-test can flag results on a spare GPIO or through a status register.
- Adds input synchronisation, deglitching, per-step timeout and a walking-zero mode.

---
 rtl/gpio_walk_pkg.sv | 25 ++
 rtl/gpio_walk_deglitch.sv | 52 +++++
 rtl/gpio_walk_checker.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/gpio_walk_pkg.sv
// Shared types for the GPIO walking-bit checker.
// FSM state, walk mode and result encodings.
package gpio_walk_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_IDLE,
    WALK,
    WAIT_END,
    DONE
  } state_t;

  typedef enum logic {
    WALK_ONE,
    WALK_ZERO
  } mode_t;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_PASS,
    RES_TIMEOUT,
    RES_MISMATCH
  } result_t;

endpackage

// File: rtl/gpio_walk_deglitch.sv
// 2-FF synchroniser plus stability filter; pulses accept once per settled value.
// Ports: clk, nrst, rearm (restart filter), io (async bus), value, accept.
module gpio_walk_deglitch #(
  parameter int WIDTH         = 34,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             rearm,
  input  logic [WIDTH-1:0] io,
  output logic [WIDTH-1:0] value,
  output logic             accept
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES);

  logic [WIDTH-1:0] s1, s2, held;
  logic [CW-1:0]    cnt;
  logic             armed;

  // held trails s2 by one cycle; cnt counts consecutive equal cycles
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s1    <= '0;
      s2    <= '0;
      held  <= '0;
      cnt   <= '0;
      armed <= 1'b0;
    end else begin
      s1 <= io;
      s2 <= s1;
      if (s2 != held) begin
        held  <= s2;
        cnt   <= CW'(1);
        armed <= 1'b1;
      end else begin
        if (cnt != CMAX) cnt <= cnt + CW'(1);
        if (accept) armed <= 1'b0;
      end
      // a new check must see the current value again, even if unchanged
      if (rearm) begin
        cnt   <= '0;
        armed <= 1'b1;
      end
    end
  end

  assign value  = held;
  assign accept = armed && (cnt == CMAX);

endmodule

// File: rtl/gpio_walk_checker.sv
// Walking-one/zero monitor with deglitch, per-step timeout and optional strict mode.
// Ports: clk, nrst, start_i, abort_i, mode_i, io_i; status busy/done/pass/fail, match, step, iter. Macro: GPIO_WALK_STRICT_EN.
module gpio_walk_checker
  import gpio_walk_pkg::*;
#(
  parameter int WIDTH          = 34,
  parameter int ITERATIONS     = 2,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                              clk,
  input  logic                              nrst,
  input  logic                              start_i,
  input  logic                              abort_i,
  input  logic                              mode_i,
  input  logic [WIDTH-1:0]                  io_i,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              pass_o,
  output logic                              fail_timeout_o,
  output logic                              fail_mismatch_o,
  output logic                              match_o,
  output logic [$clog2(WIDTH+1)-1:0]        step_o,
  output logic [$clog2(ITERATIONS+1)-1:0]   iter_o
);

  localparam int SW = $clog2(WIDTH + 1);
  localparam int IW = $clog2(ITERATIONS + 1);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [SW-1:0] STEP_IDLE = SW'(WIDTH);
  localparam logic [SW-1:0] STEP_LAST = SW'(WIDTH - 1);
  localparam logic [IW-1:0] ITER_LAST = IW'(ITERATIONS - 1);
  localparam logic [TW-1:0] TO_LAST =
    TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  state_t           state;
  mode_t            mode_q;
  result_t          res;
  logic [SW-1:0]    step;
  logic [IW-1:0]    iter;
  logic [TW-1:0]    timer;
  logic             busy, done, match;
  logic [WIDTH-1:0] value, exp_v;
  logic             accept, hit, miss, tmo, rearm;

  // step == WIDTH encodes the idle pattern
  function automatic logic [WIDTH-1:0] expect_val(
    input mode_t m, input logic [SW-1:0] k
  );
    logic [WIDTH-1:0] v;
    v = (k < STEP_IDLE) ? (WIDTH'(1) << k) : '0;
    return (m == WALK_ZERO) ? ~v : v;
  endfunction

  assign rearm = start_i && !abort_i &&
                 (state == IDLE || state == DONE);

  gpio_walk_deglitch #(
    .WIDTH         (WIDTH),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_deglitch (
    .clk    (clk),
    .nrst   (nrst),
    .rearm  (rearm),
    .io     (io_i),
    .value  (value),
    .accept (accept)
  );

  assign exp_v = expect_val(mode_q, step);
  assign hit   = accept && (value == exp_v);
  assign tmo   = TO_EN && (timer == TO_LAST);

`ifdef GPIO_WALK_STRICT_EN
  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) prev <= '0;
    else if (hit) prev <= value;
  end

  assign miss = accept && !hit && (value != prev) &&
                (state == WALK || state == WAIT_END);
`else
  assign miss = 1'b0;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state  <= IDLE;
      mode_q <= WALK_ONE;
      res    <= RES_NONE;
      step   <= '0;
      iter   <= '0;
      timer  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      match  <= 1'b0;
    end else begin
      match <= 1'b0;
      if (abort_i) begin
        state <= IDLE;
        res   <= RES_NONE;
        step  <= '0;
        iter  <= '0;
        timer <= '0;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else begin
        unique case (state)
          IDLE, DONE: begin
            if (start_i) begin
              state  <= WAIT_IDLE;
              mode_q <= mode_t'(mode_i);
              res    <= RES_NONE;
              step   <= STEP_IDLE;
              iter   <= '0;
              timer  <= '0;
              busy   <= 1'b1;
              done   <= 1'b0;
            end
          end
          WAIT_IDLE, WALK, WAIT_END: begin
            timer <= timer + TW'(1);
            if (hit) begin
              timer <= '0;
              if (state == WAIT_IDLE) begin
                match <= 1'b1;
                step  <= '0;
                state <= WALK;
              end else if (state == WALK) begin
                match <= 1'b1;
                if (step == STEP_LAST) begin
                  step  <= STEP_IDLE;
                  iter  <= iter + IW'(1);
                  state <= (iter == ITER_LAST) ? WAIT_END : WAIT_IDLE;
                end else begin
                  step <= step + SW'(1);
                end
              end else begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
                res   <= RES_PASS;
              end
            end else if (miss) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              res   <= RES_MISMATCH;
            end else if (tmo) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              res   <= RES_TIMEOUT;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy_o         = busy;
  assign done_o         = done;
  assign match_o        = match;
  assign step_o         = step;
  assign iter_o         = iter;
  assign pass_o         = (res == RES_PASS);
  assign fail_timeout_o = (res == RES_TIMEOUT);
`ifdef GPIO_WALK_STRICT_EN
  assign fail_mismatch_o = (res == RES_MISMATCH);
`else
  assign fail_mismatch_o = 1'b0;
`endif

endmodule
